// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Scan states, blank segment pattern and pin polarity helpers.
package seven_seg_scanner_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Apply pin polarity to a segment pattern.
  function automatic logic [6:0] seg_pin(
    input logic [6:0] s,
    input bit         low
  );
    return low ? ~s : s;
  endfunction

  // Apply pin polarity to a single-bit drive.
  function automatic logic bit_pin(
    input logic b,
    input bit   low
  );
    return low ? ~b : b;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// Hex nibble to seven-segment pattern, active-high.
// Bit 0 is segment a, bit 6 is segment g.
module seven_seg_scanner_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup of the glyph for one nibble.
  always_comb begin
    seg = 7'b000_0000;
    unique case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// Blank gap per slot, double-buffered digits, registered pin drive.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int BLANK          = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 5 * DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_LAST =
    CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam scan_state_e ST_INIT =
    (BLANK > 0) ? ST_BLANK : ST_SHOW;
  localparam logic [DIGITS-1:0] AN_OFF =
    AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  scan_state_e       state_q, state_d;
  logic [BW-1:0]     pend_q, pend_d;
  logic [BW-1:0]     act_q, act_d;
  logic              wrap_q, wrap_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              fs_q, fs_d;

  logic              slot_end;
  logic              boundary;
  logic [3:0]        nib;
  logic              dp_sel;
  logic              en_sel;
  logic [6:0]        dec_seg;
  logic              show;
  logic [DIGITS-1:0] an_raw;

  seven_seg_scanner_decoder u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  // Slot counter, digit index, FSM and double buffer next state.
  always_comb begin
    slot_end = (cnt_q == CNT_MAX);
    boundary = slot_end && (idx_q == IDX_MAX);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_q == BLK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end && BLANK > 0) state_d = ST_BLANK;
      default:  state_d = ST_INIT;
    endcase
    pend_d = load ? {dp_in, value} : pend_q;
    act_d  = boundary ? pend_d : act_q;
    wrap_d = boundary;
  end

  // Select the active buffer fields of the digit being scanned.
  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    en_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = act_q[4*i +: 4];
        dp_sel = act_q[4*DIGITS + i];
        en_sel = digit_en[i];
      end
    end
  end

  // Pin drive for the next output cycle.
  always_comb begin
    show   = (state_q == ST_SHOW) && en_sel;
    an_raw = show ? (DIGITS'(1) << idx_q) : '0;
    an_d   = AN_ACTIVE_LOW ? ~an_raw : an_raw;
    seg_d  = seg_pin(show ? dec_seg : SEG_BLANK,
                     SEG_ACTIVE_LOW);
    dp_d   = bit_pin(show && dp_sel, SEG_ACTIVE_LOW);
    fs_d   = wrap_q;
  end

  // All state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= ST_INIT;
      pend_q  <= '0;
      act_q   <= '0;
      wrap_q  <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= seg_pin(SEG_BLANK, SEG_ACTIVE_LOW);
      dp_q    <= bit_pin(1'b0, SEG_ACTIVE_LOW);
      fs_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner.
// DIGITS=4, DIV=8, BLANK=2, anodes active low.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'b1111;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int cyc = 0;
  int pass_cnt = 0;
  int total = 0;

  seven_seg_scanner #(
    .DIGITS(4), .DIV(8), .BLANK(2),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value),
    .dp_in(dp_in), .digit_en(digit_en), .load(load),
    .seg(seg), .dp(dp), .an(an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;
      4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;
      4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;
      4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({an, seg, dp, frame_start} !== {4'b1111, 7'h0, 1'b0, 1'b0})
      $display("FAIL reset_out got an=%b seg=%h dp=%b fs=%b",
               an, seg, dp, frame_start);
    else pass_cnt++;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_first_frame;
    value = 16'h1234;
    dp_in = 4'b0100;
    load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if ({an, frame_start} !== {4'b1111, 1'b0})
      $display("FAIL ff_c1 got an=%b fs=%b want 1111 0",
               an, frame_start);
    else pass_cnt++;
    run_to(2);
    total++;
    if (an !== 4'b1111)
      $display("FAIL ff_c2 got an=%b want 1111", an);
    else pass_cnt++;
    run_to(3);
    total++;
    if ({an, seg} !== {4'b1110, 7'h3F})
      $display("FAIL ff_c3 got an=%b seg=%h want 1110 3f", an, seg);
    else pass_cnt++;
    run_to(8);
    total++;
    if ({an, seg} !== {4'b1110, 7'h3F})
      $display("FAIL ff_c8 got an=%b seg=%h want 1110 3f", an, seg);
    else pass_cnt++;
    run_to(11);
    total++;
    if ({an, seg} !== {4'b1101, 7'h3F})
      $display("FAIL ff_c11 got an=%b seg=%h want 1101 3f", an, seg);
    else pass_cnt++;
    run_to(32);
    total++;
    if (frame_start !== 1'b0)
      $display("FAIL ff_fs32 got %b want 0", frame_start);
    else pass_cnt++;
    run_to(33);
    total++;
    if ({frame_start, an} !== {1'b1, 4'b1111})
      $display("FAIL ff_fs33 got fs=%b an=%b want 1 1111",
               frame_start, an);
    else pass_cnt++;
    run_to(35);
    total++;
    if ({an, seg, dp} !== {4'b1110, 7'h66, 1'b0})
      $display("FAIL ff_d0 got an=%b seg=%h dp=%b want 1110 66 0",
               an, seg, dp);
    else pass_cnt++;
    run_to(51);
    total++;
    if ({an, seg, dp} !== {4'b1011, 7'h5B, 1'b1})
      $display("FAIL ff_d2 got an=%b seg=%h dp=%b want 1011 5b 1",
               an, seg, dp);
    else pass_cnt++;
    run_to(59);
    total++;
    if ({an, seg} !== {4'b0111, 7'h06})
      $display("FAIL ff_d3 got an=%b seg=%h want 0111 06", an, seg);
    else pass_cnt++;
  endtask

  task automatic test_free_run;
    int last = 0;
    logic [15:0] v = 16'h1234;
    run_to(64);
    repeat (96) begin
      int c, i;
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      tick();
      c = (cyc - 1) % 8;
      i = ((cyc - 1) / 8) % 4;
      ea = (c < 2) ? 4'b1111 : ~(4'b0001 << i);
      es = (c < 2) ? 7'h0 : dec(v[i*4 +: 4]);
      ef = ((cyc - 1) % 32) == 0;
      total++;
      if ({an, seg, frame_start} !== {ea, es, ef})
        $display("FAIL run_c%0d got an=%b seg=%h fs=%b want %b %h %b",
                 cyc, an, seg, frame_start, ea, es, ef);
      else pass_cnt++;
      if (frame_start === 1'b1) begin
        if (last > 0) begin
          total++;
          if (cyc - last !== 32)
            $display("FAIL run_period got %0d want 32", cyc - last);
          else pass_cnt++;
        end
        last = cyc;
      end
    end
  endtask

  task automatic test_disable;
    digit_en = 4'b1011;
    repeat (32) begin
      int c, i;
      logic [3:0] ea;
      logic ef;
      tick();
      c = (cyc - 1) % 8;
      i = ((cyc - 1) / 8) % 4;
      ea = (c < 2 || i == 2) ? 4'b1111 : ~(4'b0001 << i);
      ef = ((cyc - 1) % 32) == 0;
      total++;
      if ({an, frame_start} !== {ea, ef})
        $display("FAIL dis_c%0d got an=%b fs=%b want %b %b",
                 cyc, an, frame_start, ea, ef);
      else pass_cnt++;
    end
    digit_en = 4'b1111;
    tick();
    total++;
    if (frame_start !== 1'b1)
      $display("FAIL dis_len got fs=%b want 1 at c%0d",
               frame_start, cyc);
    else pass_cnt++;
  endtask

  task automatic test_double_buffer;
    run_to(202);
    value = 16'hABCD;
    dp_in = 4'b0000;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    value = 16'hEF01;
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(219);
    total++;
    if ({an, seg} !== {4'b0111, 7'h06})
      $display("FAIL db_old got an=%b seg=%h want 0111 06", an, seg);
    else pass_cnt++;
    run_to(227);
    total++;
    if ({an, seg} !== {4'b1110, 7'h06})
      $display("FAIL db_d0 got an=%b seg=%h want 1110 06", an, seg);
    else pass_cnt++;
    run_to(235);
    total++;
    if ({an, seg} !== {4'b1101, 7'h3F})
      $display("FAIL db_d1 got an=%b seg=%h want 1101 3f", an, seg);
    else pass_cnt++;
    run_to(243);
    total++;
    if ({an, seg, dp} !== {4'b1011, 7'h71, 1'b0})
      $display("FAIL db_d2 got an=%b seg=%h dp=%b want 1011 71 0",
               an, seg, dp);
    else pass_cnt++;
    run_to(251);
    total++;
    if ({an, seg} !== {4'b0111, 7'h79})
      $display("FAIL db_d3 got an=%b seg=%h want 0111 79", an, seg);
    else pass_cnt++;
  endtask

  task automatic test_boundary_load;
    run_to(255);
    value = 16'h5555;
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(259);
    total++;
    if ({an, seg} !== {4'b1110, 7'h6D})
      $display("FAIL bl_d0 got an=%b seg=%h want 1110 6d", an, seg);
    else pass_cnt++;
    run_to(283);
    total++;
    if ({an, seg} !== {4'b0111, 7'h6D})
      $display("FAIL bl_d3 got an=%b seg=%h want 0111 6d", an, seg);
    else pass_cnt++;
    run_to(291);
    total++;
    if ({an, seg} !== {4'b1110, 7'h6D})
      $display("FAIL bl_pend got an=%b seg=%h want 1110 6d", an, seg);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    run_to(309);
    total++;
    if ({an, seg} !== {4'b1011, 7'h6D})
      $display("FAIL mr_pre got an=%b seg=%h want 1011 6d", an, seg);
    else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total++;
    if ({an, seg, dp, frame_start} !== {4'b1111, 7'h0, 1'b0, 1'b0})
      $display("FAIL mr_rst got an=%b seg=%h dp=%b fs=%b",
               an, seg, dp, frame_start);
    else pass_cnt++;
    rst_n = 1'b1;
    cyc = 0;
    tick();
    total++;
    if ({an, frame_start} !== {4'b1111, 1'b0})
      $display("FAIL mr_c1 got an=%b fs=%b want 1111 0",
               an, frame_start);
    else pass_cnt++;
    run_to(3);
    total++;
    if ({an, seg} !== {4'b1110, 7'h3F})
      $display("FAIL mr_c3 got an=%b seg=%h want 1110 3f", an, seg);
    else pass_cnt++;
    run_to(33);
    total++;
    if (frame_start !== 1'b1)
      $display("FAIL mr_fs got %b want 1", frame_start);
    else pass_cnt++;
    run_to(35);
    total++;
    if ({an, seg} !== {4'b1110, 7'h3F})
      $display("FAIL mr_pend got an=%b seg=%h want 1110 3f", an, seg);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_free_run();
    test_disable();
    test_double_buffer();
    test_boundary_load();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
